// File: rtl/mos6502_bus_memory_pkg.sv
// Package: mos6502_bus_pkg
// Address-map defaults, region and wait-state types, and the region decode
// shared by the 6502 side-bus responders.
package mos6502_bus_pkg;

    localparam logic [15:0] DEF_RAM_TOP   = 16'h7FFF;
    localparam logic [15:0] DEF_ROM_BASE  = 16'hC000;
    localparam logic [15:0] DEF_STOP_ADR  = 16'hFFFC;
    localparam logic [7:0]  OPEN_BUS_DATA = 8'hFF;

    typedef enum logic [1:0] {
        RGN_RAM,
        RGN_ROM,
        RGN_STOP,
        RGN_NONE
    } region_t;

    typedef enum logic [1:0] {
        WS_IDLE,
        WS_WAIT,
        WS_HOLD
    } wait_state_t;

    // The stop register is checked first so it shadows whatever region it sits in.
    function automatic region_t decode_region(
        input logic [15:0] adr,
        input logic [15:0] ram_top,
        input logic [15:0] rom_base,
        input logic [15:0] stop_adr
    );
        if (adr == stop_adr)      return RGN_STOP;
        else if (adr <= ram_top)  return RGN_RAM;
        else if (adr >= rom_base) return RGN_ROM;
        else                      return RGN_NONE;
    endfunction

endpackage

// File: rtl/mos6502_bus_memory_if.sv
// Interface: mos6502_bus_memory_if
// 6502 side bus between the CPU (master) and a memory responder (slave).
//   PHI_2, RnW, Address_bus, Data_in : CPU -> responder
//   Data_out, Data_oe, READY         : responder -> CPU
interface mos6502_bus_memory_if;

    logic        PHI_2;
    logic        RnW;
    logic [15:0] Address_bus;
    logic [7:0]  Data_in;
    logic [7:0]  Data_out;
    logic        Data_oe;
    logic        READY;

    modport master (
        output PHI_2, RnW, Address_bus, Data_in,
        input  Data_out, Data_oe, READY
    );

    modport slave (
        input  PHI_2, RnW, Address_bus, Data_in,
        output Data_out, Data_oe, READY
    );

endinterface

// File: rtl/mos6502_bus_memory_ram.sv
// Module: bus_ram
// 64Kx8 single-port synchronous RAM, read-first, one clock read latency.
//   clk   : clock
//   we    : write enable
//   addr  : shared read/write address
//   wdata : write data
//   rdata : registered read data for addr of the previous clock
module bus_ram (
    input  logic        clk,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata
);

    logic [7:0] mem [0:65535];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mos6502_bus_memory.sv
// Module: mos6502_bus_memory
// Memory/peripheral responder on the 6502 side bus: RAM/ROM reads, RAM writes,
// READY wait states for ROM reads, a write-only stop register and a timeout
// watchdog counted in PHI_2 cycles. Images can be preloaded while in reset.
//   clk, nRES                  : clock, synchronous active-low reset
//   bus (slave)                : PHI_2, RnW, Address_bus, Data_in,
//                                Data_out, Data_oe, READY
//   STOP, stop_code            : sticky stop flag and last byte written to STOP_ADR
//   timeout                    : sticky, TIMEOUT PHI_2 falls elapsed without STOP
//   ld_we, ld_addr, ld_data    : preload port, honoured only while nRES=0
module mos6502_bus_memory
    import mos6502_bus_pkg::*;
#(
    parameter logic [15:0] RAM_TOP  = DEF_RAM_TOP,
    parameter logic [15:0] ROM_BASE = DEF_ROM_BASE,
    parameter logic [15:0] STOP_ADR = DEF_STOP_ADR,
    parameter int unsigned ROM_WAIT = 0,
    parameter int unsigned TIMEOUT  = 50000
) (
    input  logic                 clk,
    input  logic                 nRES,
    mos6502_bus_memory_if.slave  bus,
    output logic                 STOP,
    output logic [7:0]           stop_code,
    output logic                 timeout,
    input  logic                 ld_we,
    input  logic [15:0]          ld_addr,
    input  logic [7:0]           ld_data
);

    localparam int unsigned CNT_W     = ($clog2(TIMEOUT + 1) > 17) ? $clog2(TIMEOUT + 1) : 17;
    localparam logic [3:0]  WAIT_LOAD = 4'(ROM_WAIT);
    localparam logic        HAS_WAIT  = (ROM_WAIT != 0);

    // PHI_2 edge detect
    logic phi_q;
    logic rise;
    logic fall;

    always_ff @(posedge clk) begin
        phi_q <= bus.PHI_2;
    end

    assign rise = bus.PHI_2 & ~phi_q;
    assign fall = ~bus.PHI_2 & phi_q;

    region_t cur_rgn;
    assign cur_rgn = decode_region(bus.Address_bus, RAM_TOP, ROM_BASE, STOP_ADR);

    // Write capture: data tracks Data_in while PHI_2 is high; a write is only
    // armed by a rise seen out of reset, so a reset inside the cycle drops it.
    logic [7:0] wr_data_q;
    logic       wr_pending_q;
    logic       commit;

    always_ff @(posedge clk) begin
        if (bus.PHI_2) begin
            wr_data_q <= bus.Data_in;
        end
        if (!nRES) begin
            wr_pending_q <= 1'b0;
        end else if (rise) begin
            wr_pending_q <= 1'b1;
        end else if (fall) begin
            wr_pending_q <= 1'b0;
        end
    end

    assign commit = nRES & fall & ~bus.RnW & wr_pending_q;

    // Memory port: preload owns the port during reset, otherwise the CPU address.
    logic        preload;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    assign preload   = ld_we & ~nRES;
    assign ram_we    = preload | (commit & (cur_rgn == RGN_RAM));
    assign ram_addr  = preload ? ld_addr : bus.Address_bus;
    assign ram_wdata = preload ? ld_data : wr_data_q;

    bus_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Read path: region is registered alongside the RAM read so both refer
    // to the same address.
    region_t    rd_rgn_q;
    logic       rd_valid_q;
    logic [7:0] data_out;

    always_ff @(posedge clk) begin
        rd_rgn_q   <= cur_rgn;
        rd_valid_q <= nRES;
    end

    always_comb begin
        data_out = '0;
        if (rd_valid_q) begin
            if (rd_rgn_q == RGN_RAM || rd_rgn_q == RGN_ROM) begin
                data_out = ram_rdata;
            end else begin
                data_out = OPEN_BUS_DATA;
            end
        end
    end

    // Wait-state FSM. WS_HOLD covers the completing cycle the CPU re-runs
    // after READY returns, so its rise does not start a fresh wait.
    wait_state_t state_q;
    wait_state_t state_d;
    logic [3:0]  wcnt_q;
    logic [3:0]  wcnt_d;

    always_ff @(posedge clk) begin
        if (!nRES) begin
            state_q <= WS_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            WS_IDLE: begin
                if (HAS_WAIT && rise && bus.RnW && cur_rgn == RGN_ROM) begin
                    state_d = WS_WAIT;
                    wcnt_d  = WAIT_LOAD;
                end
            end
            WS_WAIT: begin
                if (fall) begin
                    wcnt_d = wcnt_q - 4'd1;
                    if (wcnt_q == 4'd1) begin
                        state_d = WS_HOLD;
                    end
                end
            end
            WS_HOLD: begin
                if (fall) begin
                    state_d = WS_IDLE;
                end
            end
            default: state_d = WS_IDLE;
        endcase
    end

    assign bus.READY    = (state_q != WS_WAIT);
    assign bus.Data_out = data_out;
    assign bus.Data_oe  = bus.PHI_2 & bus.RnW & bus.READY & nRES;

    // Stop register and PHI_2 watchdog
    logic [CNT_W-1:0] cyc_cnt;

    always_ff @(posedge clk) begin
        if (!nRES) begin
            STOP      <= 1'b0;
            stop_code <= '0;
            timeout   <= 1'b0;
            cyc_cnt   <= '0;
        end else begin
            if (commit && cur_rgn == RGN_STOP) begin
                STOP      <= 1'b1;
                stop_code <= wr_data_q;
            end
            if (fall && !STOP && !timeout) begin
                cyc_cnt <= cyc_cnt + CNT_W'(1);
                if (cyc_cnt + CNT_W'(1) == CNT_W'(TIMEOUT)) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mos6502_bus_memory.sv
// Testbench: tb_mos6502_bus_memory
// Drives CPU bus cycles (directed and $urandom) into mos6502_bus_memory and
// compares against a behavioural memory-map model kept in the bench.
module tb_mos6502_bus_memory;

    localparam int unsigned ROM_WAIT = 2;
    localparam int unsigned TIMEOUT  = 20;

    logic        clk;
    logic        nRES;
    logic        STOP;
    logic [7:0]  stop_code;
    logic        timeout;
    logic        ld_we;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;

    mos6502_bus_memory_if bus ();

    mos6502_bus_memory #(
        .RAM_TOP  (16'h7FFF),
        .ROM_BASE (16'hC000),
        .STOP_ADR (16'hFFFC),
        .ROM_WAIT (ROM_WAIT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .nRES      (nRES),
        .bus       (bus),
        .STOP      (STOP),
        .stop_code (stop_code),
        .timeout   (timeout),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    bit [7:0]    m_mem [65536];
    bit          m_stop;
    bit [7:0]    m_code;
    bit          m_to;
    int unsigned m_falls;

    logic [15:0] pool [16] = '{16'h0200, 16'h0201, 16'h0202, 16'h0203,
                               16'h0204, 16'h0205, 16'h0206, 16'h0207,
                               16'h0300, 16'h7FFF, 16'h8000, 16'hBFFF,
                               16'hC000, 16'hC001, 16'hFFFE, 16'hFFFC};

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic bit is_ram(input logic [15:0] a);
        return a <= 16'h7FFF;
    endfunction

    function automatic bit is_rom(input logic [15:0] a);
        return a >= 16'hC000 && a != 16'hFFFC;
    endfunction

    function automatic logic [7:0] exp_read(input logic [15:0] a);
        if (is_ram(a) || is_rom(a)) return m_mem[a];
        return 8'hFF;
    endfunction

    // One PHI_2 fall: the watchdog counts while neither flag was set before
    // this fall; a write lands in RAM or the stop register.
    task automatic model_fall(input bit rnw, input logic [15:0] a, input logic [7:0] d, input bit pend);
        if (!m_stop && !m_to) begin
            m_falls++;
            if (m_falls == TIMEOUT) m_to = 1'b1;
        end
        if (!rnw && pend) begin
            if (a == 16'hFFFC) begin
                m_stop = 1'b1;
                m_code = d;
            end else if (is_ram(a)) begin
                m_mem[a] = d;
            end
        end
    endtask

    task automatic check_status();
        check("STOP", STOP, m_stop);
        check("stop_code", stop_code, m_code);
        check("timeout", timeout, m_to);
    endtask

    task automatic start_reset();
        @(negedge clk);
        nRES = 1'b0;
        @(negedge clk);
        m_stop = 1'b0; m_code = 8'h00; m_to = 1'b0; m_falls = 0;
        check("rst_data_out", bus.Data_out, 8'h00);
        check("rst_data_oe", bus.Data_oe, 1'b0);
        check("rst_ready", bus.READY, 1'b1);
        check_status();
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_we = 1'b0;
        if (!nRES) m_mem[a] = d;
    endtask

    task automatic end_reset();
        nRES = 1'b1;
        @(negedge clk);
    endtask

    // One CPU access, repeated while READY is low as the 6502 would.
    task automatic cpu_cycle(input bit rnw, input logic [15:0] adr, input logic [7:0] din);
        int unsigned stalls;
        int unsigned exp_stall;
        bit done;
        stalls = 0;
        done = 1'b0;
        exp_stall = (rnw && is_rom(adr)) ? ROM_WAIT : 0;
        bus.RnW = rnw; bus.Address_bus = adr; bus.Data_in = din;
        while (!done) begin
            bus.PHI_2 = 1'b0;
            repeat (2) @(negedge clk);
            check("oe_phi1", bus.Data_oe, 1'b0);
            @(negedge clk);
            bus.PHI_2 = 1'b1;
            repeat (3) @(negedge clk);
            if (bus.READY) begin
                done = 1'b1;
                if (rnw) begin
                    check("rd_data", bus.Data_out, exp_read(adr));
                    check("oe_phi2", bus.Data_oe, 1'b1);
                end else begin
                    check("oe_write", bus.Data_oe, 1'b0);
                end
            end else begin
                stalls++;
                check("oe_stall", bus.Data_oe, 1'b0);
                if (stalls > 8) done = 1'b1;
            end
            bus.PHI_2 = 1'b0;
            model_fall(rnw, adr, din, 1'b1);
            @(negedge clk);
            check_status();
        end
        check("stall_cycles", stalls, exp_stall);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] a;
        logic [7:0]  d;
        bit          rnw;

        nRES = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        bus.PHI_2 = 1'b0; bus.RnW = 1'b1; bus.Address_bus = '0; bus.Data_in = '0;
        m_stop = 1'b0; m_code = 8'h00; m_to = 1'b0; m_falls = 0;

        // Preload under reset, read back, ld_we ignored once out of reset
        start_reset();
        for (int i = 0; i < 16; i++) preload(pool[i], 8'($urandom));
        preload(16'h0200, 8'h5A);
        preload(16'hC000, 8'h22);
        preload(16'hFFFE, 8'hE7);
        end_reset();
        preload(16'h0200, 8'h00);
        cpu_cycle(1'b1, 16'h0200, 8'h00);

        // RAM write/read, ROM write dropped, unmapped reads
        cpu_cycle(1'b0, 16'h0300, 8'hC3);
        cpu_cycle(1'b1, 16'h0300, 8'h00);
        cpu_cycle(1'b0, 16'hC000, 8'h11);
        cpu_cycle(1'b1, 16'hC000, 8'h00);
        cpu_cycle(1'b1, 16'h8000, 8'h00);

        // ROM wait states vs RAM
        cpu_cycle(1'b1, 16'hFFFE, 8'h00);
        cpu_cycle(1'b1, 16'h7FFF, 8'h00);

        // Stop register; watchdog frozen afterwards
        cpu_cycle(1'b0, 16'hFFFC, 8'hAA);
        cpu_cycle(1'b1, 16'hFFFC, 8'h00);
        cpu_cycle(1'b0, 16'hFFFC, 8'h55);
        for (int i = 0; i < 25; i++) cpu_cycle(1'b1, 16'h0201, 8'h00);

        // Timeout on the TIMEOUT-th fall, not before
        start_reset();
        end_reset();
        for (int i = 0; i < 22; i++) cpu_cycle(1'b1, 16'h0202, 8'h00);
        check("timeout_final", timeout, 1'b1);
        check("stop_after_timeout", STOP, 1'b0);

        // Reset during a ROM wait
        start_reset();
        end_reset();
        bus.RnW = 1'b1; bus.Address_bus = 16'hFFFE;
        repeat (3) @(negedge clk);
        bus.PHI_2 = 1'b1;
        repeat (3) @(negedge clk);
        check("wait_entered", bus.READY, 1'b0);
        start_reset();
        bus.PHI_2 = 1'b0;
        @(negedge clk);
        end_reset();
        check("ready_after_rst", bus.READY, 1'b1);

        // Reset mid-write, with STOP set beforehand
        cpu_cycle(1'b0, 16'hFFFC, 8'h77);
        bus.RnW = 1'b0; bus.Address_bus = 16'h0204; bus.Data_in = 8'h99;
        repeat (3) @(negedge clk);
        bus.PHI_2 = 1'b1;
        repeat (3) @(negedge clk);
        start_reset();
        bus.PHI_2 = 1'b0;
        @(negedge clk);
        end_reset();
        cpu_cycle(1'b1, 16'h0204, 8'h00);

        // Short reset pulse inside the high phase, released before the fall
        bus.RnW = 1'b0; bus.Address_bus = 16'h0205; bus.Data_in = 8'h66;
        repeat (3) @(negedge clk);
        bus.PHI_2 = 1'b1;
        repeat (2) @(negedge clk);
        nRES = 1'b0;
        @(negedge clk);
        m_stop = 1'b0; m_code = 8'h00; m_to = 1'b0; m_falls = 0;
        nRES = 1'b1;
        @(negedge clk);
        bus.PHI_2 = 1'b0;
        model_fall(1'b0, 16'h0205, 8'h66, 1'b0);
        @(negedge clk);
        check_status();
        cpu_cycle(1'b1, 16'h0205, 8'h00);

        // Randomised sessions
        for (int s = 0; s < 30; s++) begin
            start_reset();
            for (int k = 0; k < 2; k++) preload(pool[$urandom_range(0, 15)], 8'($urandom));
            end_reset();
            for (int k = 0; k < 10; k++) begin
                a   = pool[$urandom_range(0, 15)];
                d   = 8'($urandom);
                rnw = ($urandom_range(0, 2) != 0);
                cpu_cycle(rnw, a, d);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
